// File: rtl/alu_regfile.sv
// alu_regfile
// -----------
// Execute-stage datapath slice for the small en/de-cryption CPU.
// A 4-entry x 9-bit register file feeds an 8-bit combinational ALU through
// two operand-select muxes. The block provides register reads, the ALU
// result, a signed-overflow flag and a branch decision.
//
// Ports:
//   clk          in   1  system clock, all state updates on the rising edge
//   rst          in   1  synchronous active-high reset, clears all registers
//   wr_en        in   1  register write enable
//   rd0_addr     in   2  read port 0 address
//   rd1_addr     in   2  read port 1 address
//   wr_addr      in   2  write address
//   wr_data      in   9  write data
//   rd0_data     out  9  register[rd0_addr], combinational
//   rd1_data     out  9  register[rd1_addr], combinational
//   out1         out  8  ALU operand A after the alusrc1 mux
//   out2         out  8  ALU operand B after the alusrc2 mux
//   alusrc1      in   2  operand A select (0 reg, 1 zero, 2 immediate, 3 zero)
//   alusrc2      in   2  operand B select (0 reg, 1 immediate, 2/3 zero)
//   instr_i      in   8  immediate field from the instruction
//   s            in   3  ALU opcode
//   f            out  8  ALU result
//   ovf          out  1  signed overflow, only meaningful for ADD
//   take_branch  out  1  branch decision, only meaningful for BEQ/BNE

module alu_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] rd0_addr,
    input  logic [1:0] rd1_addr,
    input  logic [1:0] wr_addr,
    input  logic [8:0] wr_data,
    output logic [8:0] rd0_data,
    output logic [8:0] rd1_data,
    output logic [7:0] out1,
    output logic [7:0] out2,
    input  logic [1:0] alusrc1,
    input  logic [1:0] alusrc2,
    input  logic [7:0] instr_i,
    input  logic [2:0] s,
    output logic [7:0] f,
    output logic       ovf,
    output logic       take_branch
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_INV = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SRL = 3'd4,
        OP_SLL = 3'd5,
        OP_BEQ = 3'd6,
        OP_BNE = 3'd7
    } aluOp_e;

    logic [8:0] regs_q [4];
    logic [8:0] regs_d [4];
    aluOp_e     op;
    logic [7:0] sum;

    // Next-state for the register file: hold everything, then overlay the
    // single addressed write. Register 0 is an ordinary writable register.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register file state. Reset wins over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 9'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads are asynchronous and see only the stored value, so a read of the
    // address being written returns the old contents until the edge.
    assign rd0_data = regs_q[rd0_addr];
    assign rd1_data = regs_q[rd1_addr];

    // Operand A mux. Bit 8 of the register never reaches the ALU.
    always_comb begin
        out1 = 8'h00;
        case (alusrc1)
            2'd0:    out1 = rd0_data[7:0];
            2'd2:    out1 = instr_i;
            default: out1 = 8'h00;
        endcase
    end

    // Operand B mux. Note the immediate sits on a different select code than
    // for operand A.
    always_comb begin
        out2 = 8'h00;
        case (alusrc2)
            2'd0:    out2 = rd1_data[7:0];
            2'd1:    out2 = instr_i;
            default: out2 = 8'h00;
        endcase
    end

    assign op  = aluOp_e'(s);
    assign sum = out1 + out2;

    // ALU. Flags default low so only ADD can raise ovf and only the two
    // branch compares can raise take_branch; branch ops force f to zero.
    always_comb begin
        f           = 8'h00;
        ovf         = 1'b0;
        take_branch = 1'b0;
        case (op)
            OP_ADD: begin
                f   = sum;
                ovf = (out1[7] == out2[7]) && (sum[7] != out1[7]);
            end
            OP_INV: f = ~out2;
            OP_AND: f = out1 & out2;
            OP_OR:  f = out1 | out2;
            OP_SRL: f = {1'b0, out1[7:1]};
            OP_SLL: f = {out1[6:0], 1'b0};
            OP_BEQ: take_branch = (out1 == out2);
            OP_BNE: take_branch = (out1 != out2);
            default: begin
                f           = 8'h00;
                ovf         = 1'b0;
                take_branch = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile
// --------------
// Self-checking bench for alu_regfile. A behavioural model (integer register
// array plus arithmetic definitions of each opcode) predicts every output;
// directed cases from the bring-up list are followed by a randomized run.

module tb_alu_regfile;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] rd0_addr;
    logic [1:0] rd1_addr;
    logic [1:0] wr_addr;
    logic [8:0] wr_data;
    logic [8:0] rd0_data;
    logic [8:0] rd1_data;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [1:0] alusrc1;
    logic [1:0] alusrc2;
    logic [7:0] instr_i;
    logic [2:0] s;
    logic [7:0] f;
    logic       ovf;
    logic       take_branch;

    int compareCount;
    int mismatchCount;
    int refRegs [4];

    alu_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd0_data    (rd0_data),
        .rd1_data    (rd1_data),
        .out1        (out1),
        .out2        (out2),
        .alusrc1     (alusrc1),
        .alusrc2     (alusrc2),
        .instr_i     (instr_i),
        .s           (s),
        .f           (f),
        .ovf         (ovf),
        .take_branch (take_branch)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the combinational read/ALU inputs
    task automatic applyStimulus(input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] src1, input logic [1:0] src2,
                                 input logic [7:0] imm, input logic [2:0] opc);
        rd0_addr = r0;
        rd1_addr = r1;
        alusrc1  = src1;
        alusrc2  = src2;
        instr_i  = imm;
        s        = opc;
    endtask

    // One clocked write; the model takes the value at the same edge
    task automatic writeReg(input logic [1:0] addr, input int value);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = value[8:0];
        @(posedge clk);
        refRegs[addr] = value & 'h1FF;
        #1;
        wr_en = 1'b0;
    endtask

    // Signed view of an 8-bit value
    function automatic int toSigned(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Reference ALU written from the opcode definitions in integer arithmetic
    task automatic refAlu(input int opc, input int a, input int b,
                          output int ef, output int eo, output int eb);
        int ssum;
        ef = 0; eo = 0; eb = 0;
        case (opc)
            0: begin
                ef   = (a + b) % 256;
                ssum = toSigned(a) + toSigned(b);
                eo   = (ssum > 127 || ssum < -128) ? 1 : 0;
            end
            1: ef = 255 - b;
            2: ef = a & b;
            3: ef = a | b;
            4: ef = a / 2;
            5: ef = (a * 2) % 256;
            6: eb = (a == b) ? 1 : 0;
            7: eb = (a != b) ? 1 : 0;
            default: ef = 0;
        endcase
    endtask

    // Settles, then checks every output against the model
    task automatic checkAll(input string tag);
        int a, b, ef, eo, eb;
        #1;
        a = (alusrc1 == 2'd0) ? refRegs[rd0_addr] % 256 :
            (alusrc1 == 2'd2) ? int'(instr_i) : 0;
        b = (alusrc2 == 2'd0) ? refRegs[rd1_addr] % 256 :
            (alusrc2 == 2'd1) ? int'(instr_i) : 0;
        refAlu(int'(s), a, b, ef, eo, eb);
        checkOutput({tag, ".rd0"}, 32'(rd0_data), 32'(refRegs[rd0_addr]));
        checkOutput({tag, ".rd1"}, 32'(rd1_data), 32'(refRegs[rd1_addr]));
        checkOutput({tag, ".out1"}, 32'(out1), 32'(a));
        checkOutput({tag, ".out2"}, 32'(out2), 32'(b));
        checkOutput({tag, ".f"}, 32'(f), 32'(ef));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eo));
        checkOutput({tag, ".br"}, 32'(take_branch), 32'(eb));
    endtask

    // Directed case: R0/R1 loaded, operation run, full model check plus
    // hand-computed constants for f, ovf and take_branch
    task automatic directedCase(input string tag, input int r0v, input int r1v,
                                input logic [1:0] src1, input logic [1:0] src2,
                                input logic [7:0] imm, input logic [2:0] opc,
                                input int expF, input int expOvf, input int expBr);
        writeReg(2'd0, r0v);
        writeReg(2'd1, r1v);
        applyStimulus(2'd0, 2'd1, src1, src2, imm, opc);
        checkAll(tag);
        checkOutput({tag, ".fConst"}, 32'(f), 32'(expF));
        checkOutput({tag, ".ovfConst"}, 32'(ovf), 32'(expOvf));
        checkOutput({tag, ".brConst"}, 32'(take_branch), 32'(expBr));
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        for (int i = 0; i < 4; i++) refRegs[i] = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 9'd0;
        applyStimulus(2'd0, 2'd0, 2'd0, 2'd0, 8'd0, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: every register reads zero
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 2'(i), 2'd0, 2'd0, 8'd0, 3'd0);
            #1;
            checkOutput($sformatf("reset.r%0d", i), 32'(rd0_data), 32'd0);
        end

        // Bring-up sequence through R1/R2 then R0/R3
        writeReg(2'd1, 92);
        writeReg(2'd2, 65);
        applyStimulus(2'd1, 2'd2, 2'd0, 2'd0, 8'd0, 3'd0);
        checkAll("add92_65");
        checkOutput("add92_65.fConst", 32'(f), 32'h9D);
        checkOutput("add92_65.ovfConst", 32'(ovf), 32'd1);
        writeReg(2'd0, 32);
        writeReg(2'd3, 15);
        applyStimulus(2'd0, 2'd3, 2'd0, 2'd0, 8'd0, 3'd0);
        checkAll("add32_15");
        checkOutput("add32_15.fConst", 32'(f), 32'd47);
        checkOutput("add32_15.ovfConst", 32'(ovf), 32'd0);

        // ADD boundaries, logic ops, shifts, branches
        directedCase("add127", 127, 127, 2'd0, 2'd0, 8'd0, 3'd0, 'hFE, 1, 0);
        directedCase("addAB1", 'hAB, 1, 2'd0, 2'd0, 8'd0, 3'd0, 'hAC, 0, 0);
        directedCase("addImm", 99, 0, 2'd0, 2'd1, 8'd130, 3'd0, 'hE5, 0, 0);
        directedCase("inv55", 0, 55, 2'd0, 2'd0, 8'd0, 3'd1, 'hC8, 0, 0);
        directedCase("and1", 55, 100, 2'd0, 2'd0, 8'd0, 3'd2, 'h24, 0, 0);
        directedCase("and2", 241, 15, 2'd0, 2'd0, 8'd0, 3'd2, 'h01, 0, 0);
        directedCase("and3", 'hAB, 'hA0, 2'd0, 2'd0, 8'd0, 3'd2, 'hA0, 0, 0);
        directedCase("andZero", 'hAB, 'hA0, 2'd1, 2'd0, 8'd0, 3'd2, 0, 0, 0);
        directedCase("or1", 55, 100, 2'd0, 2'd0, 8'd0, 3'd3, 'h77, 0, 0);
        directedCase("orZero", 55, 13, 2'd1, 2'd0, 8'd0, 3'd3, 13, 0, 0);
        directedCase("srl129", 129, 0, 2'd0, 2'd0, 8'd0, 3'd4, 64, 0, 0);
        directedCase("srl2", 2, 0, 2'd0, 2'd0, 8'd0, 3'd4, 1, 0, 0);
        directedCase("sll129", 129, 0, 2'd0, 2'd0, 8'd0, 3'd5, 'h02, 0, 0);
        directedCase("sll240", 240, 0, 2'd0, 2'd0, 8'd0, 3'd5, 'hE0, 0, 0);
        directedCase("beqNe", 55, 100, 2'd0, 2'd0, 8'd0, 3'd6, 0, 0, 0);
        directedCase("beqEq", 24, 24, 2'd0, 2'd0, 8'd0, 3'd6, 0, 0, 1);
        directedCase("bneNe", 55, 100, 2'd0, 2'd0, 8'd0, 3'd7, 0, 0, 1);
        directedCase("bneEq", 24, 24, 2'd0, 2'd0, 8'd0, 3'd7, 0, 0, 0);

        // Same-cycle write and read of R0: old value until the edge
        applyStimulus(2'd0, 2'd1, 2'd0, 2'd0, 8'd0, 3'd0);
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 9'd77;
        #1;
        checkOutput("noBypass.before", 32'(rd0_data), 32'd24);
        @(posedge clk);
        refRegs[0] = 77;
        #1;
        wr_en = 1'b0;
        checkOutput("noBypass.after", 32'(rd0_data), 32'd77);

        // Bit 8 visible on the read port but stripped from the operand
        writeReg(2'd2, 'h1FF);
        applyStimulus(2'd2, 2'd1, 2'd0, 2'd0, 8'd0, 3'd2);
        checkAll("bit8");
        checkOutput("bit8.rdConst", 32'(rd0_data), 32'h1FF);
        checkOutput("bit8.out1Const", 32'(out1), 32'hFF);

        // Reset takes priority over a simultaneous write
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = 9'h055;
        @(posedge clk);
        for (int i = 0; i < 4; i++) refRegs[i] = 0;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 2'(3 - i), 2'd0, 2'd0, 8'd0, 3'd0);
            #1;
            checkOutput($sformatf("rstWr.r%0d", i), 32'(rd0_data), 32'd0);
        end

        // Randomized writes and operations against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                writeReg(2'($urandom_range(0, 3)), int'($urandom_range(0, 511)));
            end
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            checkAll($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
